// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the MIPS pipeline hazard logic.
// Holds the hazard-sequencer state encoding, the hard-wired zero
// register number and the width of the per-stage control bundle that
// a bubble clears.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         CTRL_W   = 18;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side, drives hazard sources, receives stage controls
//   slave  : controller side, reads hazard sources, drives stage controls
// Hazard sources : id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read,
//                  ex_dest, branch_taken, mem_req, mem_ready
// Stage controls : pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
//                  ex_mem_en, mem_wb_en, mem_wb_bubble
// Status         : mem_error, stall_cycles[CNT_W], state[2]
interface pipeline_hazard_controller_if #(
    parameter int CNT_W = 16
) ();
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_dest;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_bubble;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             mem_wb_bubble;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cycles;
    logic [1:0]       state;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_dest,
               branch_taken, mem_req, mem_ready,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
               ex_mem_en, mem_wb_en, mem_wb_bubble, mem_error, stall_cycles,
               state
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_dest,
               branch_taken, mem_req, mem_ready,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
               ex_mem_en, mem_wb_en, mem_wb_bubble, mem_error, stall_cycles,
               state
    );
endinterface

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// Combinational load-use comparator.
// Flags when the load in EX writes a register the instruction in ID reads.
// Register 0 is hard-wired to zero, so a load targeting it never hazards.
//   id_rs, id_rt, id_uses_rs, id_uses_rt : ID operand fields and usage
//   ex_mem_read, ex_dest                 : EX load flag and destination
//   load_use                             : hazard present this cycle
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_dest,
    output logic       load_use
);
    assign load_use = ex_mem_read && (ex_dest != REG_ZERO) &&
                      ((id_uses_rs && (id_rs == ex_dest)) ||
                       (id_uses_rt && (id_rt == ex_dest)));
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline.
// Produces per-stage enables and bubble/flush controls from load-use
// hazards, taken branches and the data-memory ready handshake, with a
// bounded wait that ends in a sticky error state.
//   clk, reset : pipeline clock, asynchronous active-high reset
//   bus        : hazard sources in, stage controls and status out
module pipeline_hazard_controller
    import pipeline_pkg::*;
#(
    parameter int DELAY_SLOT  = 1,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    pipeline_hazard_controller_if.slave  bus
);
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    hz_state_t        state_q, state_d;
    logic [7:0]       wait_cnt, wait_cnt_d;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cycles;
    logic             mem_stall;
    logic             load_use;
    logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
    logic             ex_mem_en, mem_wb_en, mem_wb_bubble;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    hazard_detect u_hazard_detect (
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rs  (bus.id_uses_rs),
        .id_uses_rt  (bus.id_uses_rt),
        .ex_mem_read (bus.ex_mem_read),
        .ex_dest     (bus.ex_dest),
        .load_use    (load_use)
    );

    assign mem_stall = bus.mem_req && !bus.mem_ready;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt;
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_en     = 1'b0;
        mem_wb_bubble = 1'b0;
        // Controls stay quiet while reset is held, and the error state
        // freezes the whole pipeline until the next reset.
        if (!reset && state_q != ERROR) begin
            if (mem_stall) begin
                // MEM/WB keeps clocking but takes a bubble so the stuck
                // access is not written back twice.
                mem_wb_en     = 1'b1;
                mem_wb_bubble = 1'b1;
                if (wait_cnt >= TIMEOUT_LAST) begin
                    state_d = ERROR;
                end else begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = wait_cnt + 8'd1;
                end
            end else begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
                id_ex_en   = 1'b1;
                ex_mem_en  = 1'b1;
                mem_wb_en  = 1'b1;
                if (load_use) begin
                    // Hold PC and IF/ID one cycle; the load moves on, so
                    // the hazard is gone when ID is re-evaluated.
                    id_ex_bubble = 1'b1;
                end else begin
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    if_id_flush = bus.branch_taken && (DELAY_SLOT == 0);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            wait_cnt     <= 8'd0;
            mem_error    <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_cnt_d;
            if (state_d == ERROR) begin
                mem_error <= 1'b1;
            end
            if (!pc_en) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
        end
    end

    assign bus.pc_en         = pc_en;
    assign bus.if_id_en      = if_id_en;
    assign bus.if_id_flush   = if_id_flush;
    assign bus.id_ex_en      = id_ex_en;
    assign bus.id_ex_bubble  = id_ex_bubble;
    assign bus.ex_mem_en     = ex_mem_en;
    assign bus.mem_wb_en     = mem_wb_en;
    assign bus.mem_wb_bubble = mem_wb_bubble;
    assign bus.mem_error     = mem_error;
    assign bus.stall_cycles  = stall_cycles;
    assign bus.state         = state_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller. Two instances share one stimulus:
// dut0 (no delay slot, timeout 4, 16-bit counter) and dut1 (delay slot,
// timeout 16, 4-bit counter so saturation is reachable).
module tb_pipeline_hazard_controller;
    logic       clk;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_dest;
    logic       id_uses_rs, id_uses_rt, ex_mem_read, branch_taken;
    logic       mem_req, mem_ready;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_controller_if #(.CNT_W(16)) if0 ();
    pipeline_hazard_controller_if #(.CNT_W(4))  if1 ();

    assign if0.id_rs = id_rs;               assign if1.id_rs = id_rs;
    assign if0.id_rt = id_rt;               assign if1.id_rt = id_rt;
    assign if0.id_uses_rs = id_uses_rs;     assign if1.id_uses_rs = id_uses_rs;
    assign if0.id_uses_rt = id_uses_rt;     assign if1.id_uses_rt = id_uses_rt;
    assign if0.ex_mem_read = ex_mem_read;   assign if1.ex_mem_read = ex_mem_read;
    assign if0.ex_dest = ex_dest;           assign if1.ex_dest = ex_dest;
    assign if0.branch_taken = branch_taken; assign if1.branch_taken = branch_taken;
    assign if0.mem_req = mem_req;           assign if1.mem_req = mem_req;
    assign if0.mem_ready = mem_ready;       assign if1.mem_ready = mem_ready;

    pipeline_hazard_controller #(.DELAY_SLOT(0), .MEM_TIMEOUT(4), .CNT_W(16))
        dut0 (.clk(clk), .reset(reset), .bus(if0));
    pipeline_hazard_controller #(.DELAY_SLOT(1), .MEM_TIMEOUT(16), .CNT_W(4))
        dut1 (.clk(clk), .reset(reset), .bus(if1));

    // Packed as {pc, if_id, flush, id_ex, id_ex_bub, ex_mem, mem_wb, mem_wb_bub}
    logic [7:0]  act_ctrl  [2];
    logic [31:0] act_state [2];
    logic [31:0] act_err   [2];
    logic [31:0] act_stall [2];
    assign act_ctrl[0] = {if0.pc_en, if0.if_id_en, if0.if_id_flush, if0.id_ex_en,
                          if0.id_ex_bubble, if0.ex_mem_en, if0.mem_wb_en, if0.mem_wb_bubble};
    assign act_ctrl[1] = {if1.pc_en, if1.if_id_en, if1.if_id_flush, if1.id_ex_en,
                          if1.id_ex_bubble, if1.ex_mem_en, if1.mem_wb_en, if1.mem_wb_bubble};
    assign act_state[0] = 32'(if0.state);
    assign act_state[1] = 32'(if1.state);
    assign act_err[0]   = 32'(if0.mem_error);
    assign act_err[1]   = 32'(if1.mem_error);
    assign act_stall[0] = 32'(if0.stall_cycles);
    assign act_stall[1] = 32'(if1.stall_cycles);

    // Model parameters and state per instance
    int DS   [2] = '{0, 1};
    int TO   [2] = '{4, 16};
    int SMAX [2] = '{65535, 15};
    int m_state [2] = '{0, 0};
    int m_run   [2] = '{0, 0};
    int m_err   [2] = '{0, 0};
    int m_stall [2] = '{0, 0};
    int n_state [2], n_run [2], n_err [2], n_stall [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected control bundle from the priority rules
    function automatic logic [7:0] exp_ctrl(input int d);
        bit ms, lu;
        ms = mem_req && !mem_ready;
        lu = ex_mem_read && (ex_dest != 5'd0) &&
             ((id_uses_rs && id_rs == ex_dest) || (id_uses_rt && id_rt == ex_dest));
        if (m_state[d] == 2) return 8'h00;
        if (ms) return 8'h03;
        if (lu) return 8'h1E;
        if (branch_taken && DS[d] == 0) return 8'hF6;
        return 8'hD6;
    endfunction

    initial begin : compare
        logic [7:0] e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (reset) begin
                    m_state[d] = 0; m_run[d] = 0; m_err[d] = 0; m_stall[d] = 0;
                    e = 8'h00;
                end else begin
                    e = exp_ctrl(d);
                end
                check($sformatf("ctrl_dut%0d", d), 32'(act_ctrl[d]), 32'(e));
                check($sformatf("state_dut%0d", d), act_state[d], 32'(m_state[d]));
                check($sformatf("err_dut%0d", d), act_err[d], 32'(m_err[d]));
                check($sformatf("stall_dut%0d", d), act_stall[d], 32'(m_stall[d]));
                n_state[d] = m_state[d]; n_run[d] = m_run[d];
                n_err[d]   = m_err[d];   n_stall[d] = m_stall[d];
                if (!reset) begin
                    if (m_state[d] != 2) begin
                        if (mem_req && !mem_ready) begin
                            n_run[d]   = m_run[d] + 1;
                            n_state[d] = (n_run[d] >= TO[d]) ? 2 : 1;
                            if (n_state[d] == 2) n_err[d] = 1;
                        end else begin
                            n_state[d] = 0;
                            n_run[d]   = 0;
                        end
                    end
                    if (!e[7] && m_stall[d] < SMAX[d]) n_stall[d] = m_stall[d] + 1;
                end
            end
            @(posedge clk);
            if (!reset) begin
                for (int d = 0; d < 2; d++) begin
                    m_state[d] = n_state[d]; m_run[d] = n_run[d];
                    m_err[d]   = n_err[d];   m_stall[d] = n_stall[d];
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_dest = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1'b1; ex_dest = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    endtask

    initial begin : stimulus
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Idle after reset
        tick();
        @(negedge clk);
        check("lit_idle_ctrl", 32'(act_ctrl[0]), 32'h D6);
        check("lit_idle_state", act_state[0], 32'd0);
        check("lit_idle_stall", act_stall[0], 32'd0);

        // Reset pulse mid-run: controls drop immediately
        tick();
        reset = 1'b1;
        #1;
        check("lit_rst_ctrl", 32'(act_ctrl[0]), 32'h00);
        check("lit_rst_state", act_state[0], 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Load-use for one cycle, then the same with ex_dest = 0
        tick();
        set_load_use();
        @(negedge clk);
        check("lit_lu_ctrl0", 32'(act_ctrl[0]), 32'h1E);
        check("lit_lu_ctrl1", 32'(act_ctrl[1]), 32'h1E);
        tick();
        check("lit_lu_stall", act_stall[0], 32'd1);
        ex_dest = 5'd0; id_rs = 5'd0;
        @(negedge clk);
        check("lit_lu_r0_ctrl", 32'(act_ctrl[0]), 32'h D6);
        tick();
        clear_inputs();
        id_rt = 5'd9; id_uses_rt = 1'b1; ex_mem_read = 1'b1; ex_dest = 5'd9;
        @(negedge clk);
        check("lit_lu_rt_ctrl", 32'(act_ctrl[0]), 32'h1E);
        tick();
        clear_inputs();

        // Memory stall for 3 cycles then ready
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lit_ms_ctrl", 32'(act_ctrl[0]), 32'h03);
            tick();
            check("lit_ms_state", act_state[0], 32'd1);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("lit_ms_release", 32'(act_ctrl[0]), 32'h D6);
        tick();
        check("lit_ms_run", act_state[0], 32'd0);
        check("lit_ms_stall", act_stall[0], 32'd3);
        clear_inputs();

        // Taken branch, with and without concurrent load-use
        do_reset();
        branch_taken = 1'b1;
        @(negedge clk);
        check("lit_br_ds0", 32'(act_ctrl[0]), 32'h F6);
        check("lit_br_ds1", 32'(act_ctrl[1]), 32'h D6);
        tick();
        set_load_use();
        @(negedge clk);
        check("lit_br_lu", 32'(act_ctrl[0]), 32'h1E);
        tick();
        clear_inputs();

        // Memory stall together with load-use
        mem_req = 1'b1;
        set_load_use();
        @(negedge clk);
        check("lit_ms_lu", 32'(act_ctrl[0]), 32'h03);
        tick();
        clear_inputs();
        tick();

        // Timeout: dut0 errors after 4 stall cycles, dut1 after 16
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("lit_to_state", act_state[0], 32'd2);
        check("lit_to_err", act_err[0], 32'd1);
        @(negedge clk);
        check("lit_to_ctrl", 32'(act_ctrl[0]), 32'h00);
        for (int i = 0; i < 16; i++) tick();
        mem_req = 1'b0;
        tick();
        tick();
        check("lit_to_hold0", act_state[0], 32'd2);
        check("lit_to_hold1", act_state[1], 32'd2);
        check("lit_to_sat1", act_stall[1], 32'd15);
        reset = 1'b1;
        #1;
        check("lit_to_rst_state", act_state[0], 32'd0);
        check("lit_to_rst_err", act_err[0], 32'd0);
        check("lit_to_rst_stall", act_stall[0], 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Reset while waiting on memory
        mem_req = 1'b1;
        tick();
        tick();
        check("lit_mw_state", act_state[0], 32'd1);
        reset = 1'b1;
        #1;
        check("lit_mw_rst_state", act_state[0], 32'd0);
        check("lit_mw_rst_stall", act_stall[0], 32'd0);
        mem_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
